carfield_boot_sequencer: RTL and testbench

//  Hardware boot sequencer for Carfield's N boot domains (hostd, safed, accelerator clusters, ...).

---
 rtl/carfield_pkg.sv | 36 +++
 rtl/carfield_boot_sequencer.sv | 159 +++++++++++++++
 tb/tb_carfield_boot_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/carfield_pkg.sv
// Shared types, defaults and the lowest-enabled-domain search used by the Carfield boot sequencer.
package carfield_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GATE,
        RELEASE,
        FETCH,
        DONE,
        ERROR
    } boot_seq_state_e;

    localparam int unsigned BootSeqNumDomains = 3;
    localparam int unsigned BootSeqRelDelay   = 8;
    localparam int unsigned BootSeqMaxDomains = 32;

    // Lowest index in [from, num) whose enable bit is set; returns num when none qualifies.
    function automatic int unsigned boot_seq_next_dom(
        input logic [BootSeqMaxDomains-1:0] en,
        input int unsigned                  from,
        input int unsigned                  num
    );
        int unsigned res;
        logic        found;
        res   = num;
        found = 1'b0;
        for (int unsigned i = 0; i < BootSeqMaxDomains; i++) begin
            if (!found && i >= from && i < num && en[i]) begin
                res   = i;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/carfield_boot_sequencer.sv
// Releases domain resets then fetch enables one domain at a time, lowest index first; RelDelay cycles reset->fetch.
// Stalls in FETCH until dom_ready_i of the current domain; CARFIELD_BOOT_SEQ_TIMEOUT_EN adds a FETCH timeout to ERROR.
module carfield_boot_sequencer
    import carfield_pkg::*;
#(
    parameter int unsigned NumDomains    = BootSeqNumDomains,
    parameter int unsigned CntWidth      = 16,
`ifdef CARFIELD_BOOT_SEQ_TIMEOUT_EN
    parameter int unsigned TimeoutCycles = 16'hFFFF,
`endif
    parameter int unsigned RelDelay      = BootSeqRelDelay,
    localparam int unsigned IdxW         = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic                  secure_boot_i,
    input  logic                  secd_ready_i,
    input  logic [NumDomains-1:0] dom_en_i,
    input  logic [NumDomains-1:0] dom_ready_i,
    output logic [NumDomains-1:0] dom_rst_no,
    output logic [NumDomains-1:0] dom_fetch_en_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [IdxW-1:0]       cur_dom_o
);

    localparam logic [CntWidth-1:0] RelLast = CntWidth'(RelDelay - 1);
    localparam logic [IdxW-1:0]     LastIdx = IdxW'(NumDomains - 1);
`ifdef CARFIELD_BOOT_SEQ_TIMEOUT_EN
    localparam logic [CntWidth-1:0] ToLast  = CntWidth'(TimeoutCycles - 1);
`endif

    boot_seq_state_e             state_q, state_d;
    logic [NumDomains-1:0]       en_q, en_d;
    logic [NumDomains-1:0]       rst_q, rst_d;
    logic [NumDomains-1:0]       fen_q, fen_d;
    logic                        sec_q, sec_d;
    logic [IdxW-1:0]             cur_q, cur_d;
    logic [CntWidth-1:0]         cnt_q, cnt_d;

    logic [CntWidth-1:0]          cnt_inc;
    logic [BootSeqMaxDomains-1:0] scan_en;
    int unsigned                  scan_from;
    int unsigned                  scan_idx;
    logic                         scan_take;

    // GATE scans from the current index, FETCH from the one after the domain just acknowledged.
    always_comb begin
        scan_en                 = '0;
        scan_en[NumDomains-1:0] = en_q;
        scan_from               = (state_q == FETCH) ? (32'(cur_q) + 32'd1) : 32'(cur_q);
        scan_idx                = boot_seq_next_dom(scan_en, scan_from, NumDomains);
        cnt_inc                 = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        rst_d     = rst_q;
        fen_d     = fen_q;
        sec_d     = sec_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        scan_take = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = GATE;
                    en_d    = dom_en_i;
                    sec_d   = secure_boot_i;
                end
            end
            GATE: begin
                if (!sec_q || secd_ready_i) scan_take = 1'b1;
            end
            RELEASE: begin
                if (cnt_q == RelLast) begin
                    state_d      = FETCH;
                    cnt_d        = '0;
                    fen_d[cur_q] = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            FETCH: begin
                if (dom_ready_i[cur_q]) begin
                    cur_d     = (cur_q == LastIdx) ? cur_q : cur_q + 1'b1;
                    scan_take = 1'b1;
`ifdef CARFIELD_BOOT_SEQ_TIMEOUT_EN
                end else if (cnt_q == ToLast) begin
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_inc;
`endif
                end
            end
            DONE, ERROR: ;
            default: state_d = IDLE;
        endcase

        if (scan_take) begin
            if (scan_idx < NumDomains) begin
                state_d             = RELEASE;
                cur_d               = IdxW'(scan_idx);
                rst_d[IdxW'(scan_idx)] = 1'b1;
                cnt_d               = '0;
            end else begin
                state_d = DONE;
            end
        end

        // Abort wins over everything, including a start in the same cycle.
        if (clear_i) begin
            state_d = IDLE;
            en_d    = '0;
            rst_d   = '0;
            fen_d   = '0;
            sec_d   = 1'b0;
            cur_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            en_q    <= '0;
            rst_q   <= '0;
            fen_q   <= '0;
            sec_q   <= 1'b0;
            cur_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            rst_q   <= rst_d;
            fen_q   <= fen_d;
            sec_q   <= sec_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dom_rst_no     = rst_q;
    assign dom_fetch_en_o = fen_q;
    assign busy_o         = (state_q == GATE) || (state_q == RELEASE) || (state_q == FETCH);
    assign done_o         = (state_q == DONE);
    assign cur_dom_o      = cur_q;
`ifdef CARFIELD_BOOT_SEQ_TIMEOUT_EN
    assign error_o        = (state_q == ERROR);
`else
    assign error_o        = 1'b0;
`endif

endmodule

// File: tb/tb_carfield_boot_sequencer.sv
// Randomized bench: each boot run is predicted as a timeline of release/fetch/ack cycles and checked every cycle.
module tb_carfield_boot_sequencer;

    localparam int N   = 3;
    localparam int REL = 8;
    localparam int TO  = 100;
    localparam int INF = 1 << 30;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic         clear_i = 1'b0;
    logic         secure_boot_i = 1'b0;
    logic         secd_ready_i = 1'b0;
    logic [N-1:0] dom_en_i = '0;
    logic [N-1:0] dom_ready_i = '0;
    logic [N-1:0] dom_rst_no;
    logic [N-1:0] dom_fetch_en_o;
    logic         busy_o;
    logic         done_o;
    logic         error_o;
    logic [1:0]   cur_dom_o;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    carfield_boot_sequencer #(
        .NumDomains    (N),
        .CntWidth      (16),
`ifdef CARFIELD_BOOT_SEQ_TIMEOUT_EN
        .TimeoutCycles (TO),
`endif
        .RelDelay      (REL)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .clear_i        (clear_i),
        .secure_boot_i  (secure_boot_i),
        .secd_ready_i   (secd_ready_i),
        .dom_en_i       (dom_en_i),
        .dom_ready_i    (dom_ready_i),
        .dom_rst_no     (dom_rst_no),
        .dom_fetch_en_o (dom_fetch_en_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .cur_dom_o      (cur_dom_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One boot run. Entered at a negedge; start is sampled at edge s, clear at edge x.
    // hang: index of an enabled domain that never acknowledges (timeout build only), -1 for none.
    // clr_mode: 0 = clear after completion, 1 = clear at a random point, 2 = clear during FETCH of domain 1.
    task automatic run_seq(input logic [N-1:0] en, input bit sec, input int w,
                           input int dfix, input int hang, input int clr_mode);
        int rel_t[N], fen_t[N], cmp_t[N], lo_t[N], d;
        int s, t, end_t, x, last, ec;
        bit err, live;
        logic [N-1:0] er, ef, rdy;

        s    = cyc + 2;
        t    = s + 1 + (sec ? w : 0);
        err  = 1'b0;
        last = -1;
        for (int i = 0; i < N; i++) begin
            rel_t[i] = INF; fen_t[i] = INF; cmp_t[i] = INF; lo_t[i] = INF;
        end
        for (int i = 0; i < N; i++) begin
            if (en[i] && !err) begin
                d        = (dfix >= 0) ? dfix : int'($urandom_range(0, 20));
                rel_t[i] = t;
                fen_t[i] = t + REL;
                last     = i;
                if (i == hang) begin
                    err = 1'b1;
                    t   = fen_t[i] + TO;
                end else begin
                    cmp_t[i] = fen_t[i] + d + 1;
                    lo_t[i]  = (d == 0) ? fen_t[i] - 2 : fen_t[i] + d;
                    t        = cmp_t[i];
                end
            end
        end
        end_t = t;
        case (clr_mode)
            1:       x = s + int'($urandom_range(1, end_t - s + 3));
            2:       x = fen_t[1] + 3;
            default: x = end_t + 4;
        endcase

        while (cyc <= x + 2) begin
            live = (cyc < x);
            er = '0; ef = '0; ec = 0;
            for (int i = 0; i < N; i++) begin
                if (live && cyc >= rel_t[i]) begin er[i] = 1'b1; ec = i; end
                if (live && cyc >= fen_t[i]) ef[i] = 1'b1;
            end
            if (live && !err && cyc >= end_t && last >= 0) ec = (last + 1 < N) ? last + 1 : N - 1;
            check_eq("dom_rst_no", 32'(dom_rst_no), 32'(er));
            check_eq("fetch_en", 32'(dom_fetch_en_o), 32'(ef));
            check_eq("busy", 32'(busy_o), 32'(live && cyc >= s && cyc < end_t));
            check_eq("done", 32'(done_o), 32'(live && !err && cyc >= end_t));
            check_eq("error", 32'(error_o), 32'(live && err && cyc >= end_t));
            check_eq("cur_dom", 32'(cur_dom_o), 32'(ec));

            start_i       = (cyc == s - 1) || (cyc == x - 1) ||
                            (cyc >= s && cyc < x - 1 && $urandom_range(0, 3) == 0);
            clear_i       = (cyc == x - 1);
            dom_en_i      = (cyc == s - 1) ? en : N'($urandom);
            secure_boot_i = (cyc == s - 1) ? sec : 1'($urandom_range(0, 1));
            secd_ready_i  = (sec && cyc >= s && cyc < x) ? (cyc >= s + w) : 1'($urandom_range(0, 1));
            rdy           = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if (cyc < x && cyc >= rel_t[i] && cyc <= cmp_t[i] - 1)
                    rdy[i] = (cyc >= lo_t[i] && cyc <= cmp_t[i] - 1);
            end
            dom_ready_i = rdy;
            @(negedge clk_i);
        end
        start_i = 1'b0;
        clear_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check_eq("rst_state_rst_no", 32'(dom_rst_no), 32'd0);
        check_eq("rst_state_fetch", 32'(dom_fetch_en_o), 32'd0);
        check_eq("rst_state_busy", 32'(busy_o), 32'd0);
        check_eq("rst_state_done", 32'(done_o), 32'd0);
        check_eq("rst_state_error", 32'(error_o), 32'd0);
        check_eq("rst_state_cur", 32'(cur_dom_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_seq(3'b111, 1'b0, 0, 20, -1, 0);
        run_seq(3'b111, 1'b1, 500, -1, -1, 0);
        run_seq(3'b101, 1'b0, 0, -1, -1, 0);
        run_seq(3'b111, 1'b0, 0, 25, -1, 2);
        run_seq(3'b111, 1'b0, 0, 0, -1, 0);
        run_seq(3'b000, 1'b0, 0, 0, -1, 0);
`ifdef CARFIELD_BOOT_SEQ_TIMEOUT_EN
        run_seq(3'b111, 1'b0, 0, -1, 1, 0);
        run_seq(3'b111, 1'b0, 0, 0, 1, 0);
        for (int r = 0; r < 6; r++)
            run_seq(3'b111, 1'($urandom_range(0, 1)), int'($urandom_range(0, 30)), -1,
                    int'($urandom_range(0, N - 1)), 0);
`endif
        for (int r = 0; r < 25; r++)
            run_seq(N'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 30)), -1, -1,
                    ($urandom_range(0, 2) == 0) ? 1 : 0);

        // Asynchronous reset in the middle of domain 0's FETCH phase.
        dom_ready_i   = '0;
        dom_en_i      = 3'b111;
        secure_boot_i = 1'b0;
        start_i       = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (12) @(negedge clk_i);
        check_eq("pre_arst_rst_no", 32'(dom_rst_no), 32'd1);
        check_eq("pre_arst_fetch", 32'(dom_fetch_en_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("arst_rst_no", 32'(dom_rst_no), 32'd0);
        check_eq("arst_fetch", 32'(dom_fetch_en_o), 32'd0);
        check_eq("arst_busy", 32'(busy_o), 32'd0);
        check_eq("arst_cur", 32'(cur_dom_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_seq(3'b011, 1'b0, 0, -1, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
